spi_baud_generator: RTL and testbench
=====================================

# spi_baud_generator

Generates the SPI serial clock `sclk` from `pclk` and the one-cycle strobes `flaglow`, `flaghigh`, `flagslow` and `flagshigh`. These strobes drive the MISO sampling and MOSI launch counters in the SPI shift-register stage. The block sits between the APB register/control logic and the shift register. While a transfer is active, it holds the clock configuration stable in shadow registers.

## Interface
Parameters: none (divider width fixed at 12 bits).

Ports:
- `pclk` input 1: system clock; all state changes on its rising edge.
- `preset` input 1: reset, asynchronous, active-high.
- `ss` input 1: slave select, active-low; transfer active while 0.
- `spi_mode` input 2: 00 = run, 01 = wait, 10/11 = stop.
- `spiswai` input 1: when 1, SPI clock is halted in wait mode.
- `cpol` input 1: clock polarity; idle level of `sclk`.
- `cpha` input 1: clock phase; routed to the shift stage only, no effect on this block.
- `sppr` input 3: baud prescaler select.
- `spr` input 3: baud rate select.
- `sclk` output 1: serial clock, registered.
- `baudratedivisor` output 12: current divisor from shadow values, combinational.
- `flaglow` output 1: strobe; `sclk` is low and will rise at the next `pclk` edge.
- `flaghigh` output 1: strobe; `sclk` is high and will fall at the next `pclk` edge.
- `flagslow` output 1: early strobe, one `pclk` before `flaglow`.
- `flagshigh` output 1: early strobe, one `pclk` before `flaghigh`.

## Operation
- Divisor and half-period:
  - divisor = (sh_sppr+1) << (sh_spr+1), range 2..2048 (fits 12 bits).
  - half = (sh_sppr+1) << sh_spr, range 1..1024.
- Run condition: running = ~ss & (spi_mode==00 | (spi_mode==01 & ~spiswai)).
- Shadow registers `sh_sppr`, `sh_spr`, `sh_cpol`:
  - Load the live inputs on every `pclk` edge where running=0.
  - Hold while running=1.
  - Configuration changes during a transfer therefore take effect only after running drops.
- 12-bit counter `cnt`:
  - If running=0: cnt<=0 and sclk<=cpol (live input).
  - If running=1 and cnt==half-1: cnt<=0 and sclk<=~sclk.
  - If running=1 otherwise: cnt<=cnt+1.
- Strobes are combinational, all gated by running:
  - flaglow = sclk==0 & cnt==half-1.
  - flaghigh = sclk==1 & cnt==half-1.
  - flagslow = sclk==0 & cnt==half-2.
  - flagshigh = sclk==1 & cnt==half-2.
- Boundary half==1: cnt is always 0, so the early strobes equal the normal strobes (flagslow=flaglow, flagshigh=flaghigh).
- At most one of the four strobes is high in any cycle, except in the half==1 pairing.
- Stop/abort mid-transfer: when running falls, all strobes drop the same cycle. At the next edge, cnt=0 and sclk=cpol. No partial-period completion.

## Timing
- Reset (`preset`=1, asynchronous): sclk=0, cnt=0, sh_sppr=0, sh_spr=0, sh_cpol=0. All strobes read 0 and `baudratedivisor` reads 2.
- First running cycle (ss falls with mode run): cnt=0 and sclk=sh_cpol.
- First `sclk` toggle occurs at the edge ending running cycle index half-1 (0-based), i.e. half cycles after start.
- Each subsequent toggle follows every half `pclk` cycles; the `sclk` period is divisor `pclk` cycles.
- One byte (16 `sclk` edges) takes 8·divisor `pclk` cycles.
- Strobe-to-edge latency: each strobe is high in the `pclk` cycle immediately before the `sclk` edge it announces. The early strobes lead by 2 cycles (1 when half==1).
- `ss` rising mid-period and wait-mode halt behave as described under stop/abort.
- Simultaneous `ss` fall and config change: the shadow values captured at that edge are the ones loaded while running was still 0.

## Test plan
- Reset: assert `preset` mid-count with `sclk`=1 -> `sclk`=0, cnt=0 and all flags 0 immediately; `baudratedivisor`=2.
- sppr=1, spr=0, cpol=0, mode=00, ss 1->0 -> half=2 and `baudratedivisor`=4. `sclk` is low for 2 cycles then high for 2, repeating. `flagslow` fires at cnt 0 and `flaglow` at cnt 1 during the low phase; `flagshigh` and `flaghigh` fire likewise during the high phase.
- sppr=2, spr=2, cpol=1 -> `baudratedivisor`=24. `sclk`=1 while ss=1. After ss=0, the first fall comes 12 cycles later, preceded by `flaghigh` in cycle 11 and `flagshigh` in cycle 10.
- Change sppr 1->5 while ss=0 -> the period stays 4 cycles. Raise ss, then lower it -> the period becomes 12.
- mode=01 with spiswai=1 mid-transfer -> strobes drop the same cycle, then `sclk`=cpol and cnt=0. With spiswai=0 the clock runs normally; mode=10 always halts.
- sppr=0, spr=0 -> `sclk` toggles every cycle. `flagslow`==`flaglow` and `flagshigh`==`flaghigh`, alternating each cycle.

Source files
------------

// File: rtl/spi_baud_generator.sv
// SPI serial clock generator: divides pclk into sclk and produces the
// edge-announcing strobes used by the shift-register stage.
module spi_baud_generator (
  input  logic        pclk,
  input  logic        preset,
  input  logic        ss,
  input  logic [1:0]  spi_mode,
  input  logic        spiswai,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [2:0]  sppr,
  input  logic [2:0]  spr,
  output logic        sclk,
  output logic [11:0] baudratedivisor,
  output logic        flaglow,
  output logic        flaghigh,
  output logic        flagslow,
  output logic        flagshigh
);

  logic [2:0]  sh_sppr;
  logic [2:0]  sh_spr;
  logic        sh_cpol;
  logic [11:0] cnt;
  logic [11:0] presc;
  logic [11:0] half;
  logic [11:0] half_m1;
  logic [11:0] half_m2;
  logic        running;
  logic        at_end;
  logic        at_early;
  logic        strobe_en;
  logic [1:0]  cfg_unused;

  // cpha belongs to the shift stage; sh_cpol mirrors the idle level loaded with sclk
  assign cfg_unused = {cpha, sh_cpol};

  assign running = ~ss & ((spi_mode == 2'b00) | ((spi_mode == 2'b01) & ~spiswai));

  assign presc           = {9'd0, sh_sppr} + 12'd1;
  assign half            = presc << sh_spr;
  assign baudratedivisor = presc << ({1'b0, sh_spr} + 4'd1);
  assign half_m1         = half - 12'd1;
  assign half_m2         = half - 12'd2;

  assign at_end   = (cnt == half_m1);
  // with a one-cycle half period the early strobe coincides with the normal one
  assign at_early = (half == 12'd1) ? at_end : (cnt == half_m2);

  assign strobe_en = running & ~preset;
  assign flaglow   = strobe_en & ~sclk & at_end;
  assign flaghigh  = strobe_en &  sclk & at_end;
  assign flagslow  = strobe_en & ~sclk & at_early;
  assign flagshigh = strobe_en &  sclk & at_early;

  // Shadow configuration: tracks live inputs only while idle
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      sh_sppr <= 3'd0;
      sh_spr  <= 3'd0;
      sh_cpol <= 1'b0;
    end else if (!running) begin
      sh_sppr <= sppr;
      sh_spr  <= spr;
      sh_cpol <= cpol;
    end
  end

  // Half-period counter and sclk toggle
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt  <= 12'd0;
      sclk <= 1'b0;
    end else if (!running) begin
      cnt  <= 12'd0;
      sclk <= cpol;
    end else if (at_end) begin
      cnt  <= 12'd0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 12'd1;
    end
  end

endmodule

// File: tb/tb_spi_baud_generator.sv
// Bench for spi_baud_generator: directed scenarios followed by random
// configuration/mode traffic, all compared against a cycle-count model.
module tb_spi_baud_generator;

  logic        pclk;
  logic        preset;
  logic        ss;
  logic [1:0]  spi_mode;
  logic        spiswai;
  logic        cpol;
  logic        cpha;
  logic [2:0]  sppr;
  logic [2:0]  spr;
  logic        sclk;
  logic [11:0] baudratedivisor;
  logic        flaglow;
  logic        flaghigh;
  logic        flagslow;
  logic        flagshigh;

  int checks = 0;
  int errors = 0;

  // model: shadow config plus number of running edges since the last idle edge
  int m_sppr;
  int m_spr;
  int m_cpol;
  int k;

  spi_baud_generator dut (
    .pclk(pclk), .preset(preset), .ss(ss), .spi_mode(spi_mode),
    .spiswai(spiswai), .cpol(cpol), .cpha(cpha), .sppr(sppr), .spr(spr),
    .sclk(sclk), .baudratedivisor(baudratedivisor), .flaglow(flaglow),
    .flaghigh(flaghigh), .flagslow(flagslow), .flagshigh(flagshigh)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_running();
    return !ss && (spi_mode == 2'b00 || (spi_mode == 2'b01 && !spiswai)) && !preset;
  endfunction

  task automatic model_reset();
    m_sppr = 0;
    m_spr  = 0;
    m_cpol = 0;
    k      = 0;
  endtask

  task automatic check_all(input string tag);
    int   half;
    int   c;
    int   early;
    bit   s;
    bit   run;
    logic [3:0] exp_f;
    logic [3:0] obs_f;
    half  = (m_sppr + 1) << m_spr;
    c     = k % half;
    s     = m_cpol[0] ^ (((k / half) % 2) == 1);
    run   = model_running();
    early = (half == 1) ? 0 : half - 2;
    exp_f = {run && !s && c == half - 1, run && s && c == half - 1,
             run && !s && c == early,    run && s && c == early};
    obs_f = {flaglow, flaghigh, flagslow, flagshigh};
    chk({tag, "_sclk"}, {11'd0, sclk}, 12'(s));
    chk({tag, "_div"}, baudratedivisor, 12'(2 * half));
    chk({tag, "_flags"}, {8'd0, obs_f}, {8'd0, exp_f});
    chk({tag, "_cnt"}, dut.cnt, 12'(c));
  endtask

  // one pclk: check mid-cycle, then advance the model across the rising edge
  task automatic cycle(input string tag);
    bit run;
    @(negedge pclk);
    check_all(tag);
    run = model_running();
    @(posedge pclk);
    #1;
    if (run) k++;
    else begin
      k      = 0;
      m_sppr = int'(sppr);
      m_spr  = int'(spr);
      m_cpol = int'(cpol);
    end
  endtask

  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    preset   = 1'b1;
    ss       = 1'b1;
    spi_mode = 2'b00;
    spiswai  = 1'b0;
    cpol     = 1'b0;
    cpha     = 1'b0;
    sppr     = 3'd0;
    spr      = 3'd0;
    model_reset();
    #1;
    chk("rst_sclk", {11'd0, sclk}, 12'd0);
    chk("rst_div", baudratedivisor, 12'd2);
    chk("rst_flags", {8'd0, flaglow, flaghigh, flagslow, flagshigh}, 12'd0);
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;

    // half = 2: two cycles low, two high
    sppr = 3'd1; spr = 3'd0; cpol = 1'b0;
    cycles("idle4", 2);
    ss = 1'b0;
    chk("div4", baudratedivisor, 12'd4);
    cycles("run4", 12);

    // asynchronous reset while sclk is high
    for (int i = 0; i < 50 && sclk !== 1'b1; i++) cycle("seek_high");
    chk("seek_high_reached", {11'd0, sclk}, 12'd1);
    #1 preset = 1'b1;
    #1;
    chk("arst_sclk", {11'd0, sclk}, 12'd0);
    chk("arst_cnt", dut.cnt, 12'd0);
    chk("arst_flags", {8'd0, flaglow, flaghigh, flagslow, flagshigh}, 12'd0);
    chk("arst_div", baudratedivisor, 12'd2);
    #1 preset = 1'b0;
    model_reset();
    cycles("post_rst", 3);

    // divisor 24, idle-high clock
    ss = 1'b1; sppr = 3'd2; spr = 3'd2; cpol = 1'b1;
    cycles("idle24", 3);
    chk("idle24_sclk", {11'd0, sclk}, 12'd1);
    chk("div24", baudratedivisor, 12'd24);
    ss = 1'b0;
    cycles("run24", 30);

    // config change during a transfer is deferred
    ss = 1'b1; sppr = 3'd1; spr = 3'd0; cpol = 1'b0;
    cycles("idle_sh", 2);
    ss = 1'b0;
    cycles("run_sh", 4);
    sppr = 3'd5;
    cycles("hold_sh", 10);
    chk("hold_div", baudratedivisor, 12'd4);
    ss = 1'b1;
    cycles("reload_sh", 2);
    ss = 1'b0;
    cycles("run12", 14);
    chk("div12", baudratedivisor, 12'd12);

    // wait-mode halt, wait-mode run, stop
    spi_mode = 2'b01; spiswai = 1'b1;
    cycles("wait_halt", 4);
    spiswai = 1'b0;
    cycles("wait_run", 8);
    spi_mode = 2'b10;
    cycles("stop", 3);
    spi_mode = 2'b00;
    cycles("resume", 6);

    // fastest rate: toggle every cycle
    ss = 1'b1; sppr = 3'd0; spr = 3'd0;
    cycles("idle2", 2);
    ss = 1'b0;
    cycles("run2", 8);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) ss = ~ss;
      if ($urandom_range(0, 29) == 0) spi_mode = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 15) == 0) spiswai = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        sppr = 3'($urandom);
        spr  = 3'($urandom_range(0, 3));
        cpol = 1'($urandom);
        cpha = 1'($urandom);
      end
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
